// File: rtl/sr_cmd_seq.sv
// ----------------------------------------------------------------------------
// sr_cmd_seq
//
// Command sequencer for a downstream SR flip-flop. Commands {op, len} are
// queued in a small FIFO. Each one is played out as a registered drive
// pattern (s / r / clear / preset) for len+1 cycles. Every command is followed
// by a one-cycle all-zero GAP so that consecutive patterns never touch.
//
// Optional feature: define SR_BOTH_BLOCK_EN to treat the BOTH opcode (s=r=1)
// as illegal. It then drives the HOLD pattern and pulses err, like a
// reserved opcode.
//
// Parameters
//   FIFO_DEPTH  command FIFO depth; power of two, >= 2. The fifo_count port is
//               3 bits wide, so it reports occupancy exactly up to depth 4.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   cmd_valid   in   command offered
//   cmd_op      in   [2:0] opcode: 0 HOLD, 1 SET, 2 RESET, 3 BOTH, 4 CLEAR,
//                    5 PRESET, 6/7 reserved
//   cmd_len     in   [3:0] drive length minus one
//   cmd_ready   out  FIFO can accept a command
//   s, r        out  registered set / reset drives
//   clear       out  registered clear drive
//   preset      out  registered preset drive
//   busy        out  high in DRIVE or GAP
//   err         out  one-cycle pulse on the first DRIVE cycle of an illegal op
//   fifo_count  out  [2:0] FIFO occupancy
// ----------------------------------------------------------------------------
module sr_cmd_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_len,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    output logic       clear,
    output logic       preset,
    output logic       busy,
    output logic       err,
    output logic [2:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    // Returns {err, s, r, clear, preset} for an opcode.
    function automatic logic [4:0] decode(input logic [2:0] op);
        logic [4:0] v;
        case (op)
            3'd0:    v = 5'b0_0000;
            3'd1:    v = 5'b0_1000;
            3'd2:    v = 5'b0_0100;
`ifdef SR_BOTH_BLOCK_EN
            3'd3:    v = 5'b1_0000;
`else
            3'd3:    v = 5'b0_1100;
`endif
            3'd4:    v = 5'b0_0010;
            3'd5:    v = 5'b0_0001;
            default: v = 5'b1_0000;
        endcase
        return v;
    endfunction

    // FIFO storage and bookkeeping
    logic [6:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Sequencer state
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_drv;     // {s, r, clear, preset}
    logic       r_err;

    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic [6:0] w_head;
    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_drv_nxt;
    logic       w_err_nxt;

    assign cmd_ready = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_empty   = (r_count == '0);
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: the command storage has no reset; emptiness is tracked by the
    // pointers and count alone, so the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_len};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: every signal gets a default before the case statement, so no
    // path through this block can leave a value held (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_drv_nxt   = 4'b0000;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = !w_empty;
            end
            ST_DRIVE: begin
                // r_cnt counts the remaining extra cycles of the pattern.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    w_drv_nxt = r_drv;
                end
            end
            ST_GAP: begin
                if (w_empty) w_state_nxt = ST_IDLE;
                else         w_pop       = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A pop loads the head command and registers its pattern, so it
        // appears on the outputs in the cycle right after the pop edge.
        if (w_pop) begin
            w_state_nxt            = ST_DRIVE;
            w_cnt_nxt              = w_head[3:0];
            {w_err_nxt, w_drv_nxt} = decode(w_head[6:4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_drv   <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drv   <= w_drv_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign {s, r, clear, preset} = r_drv;
    assign err                   = r_err;
    assign busy                  = (r_state != ST_IDLE);
    assign fifo_count            = 3'(r_count);

endmodule

// File: tb/tb_sr_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_seq
//
// Self-checking bench for sr_cmd_seq. The reference model keeps a list of
// accepted commands. For each one it stores the acceptance edge and the first
// DRIVE cycle, computed in closed form:
//   start = max(accept + 1, previous_start + previous_len + 2)
// The expected outputs in any cycle follow from which command window covers
// that cycle. Occupancy is the number of commands accepted minus the number
// started.
// ----------------------------------------------------------------------------
module tb_sr_cmd_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       cmd_ready, s, r, clear, preset, busy, err;
    logic [2:0] fifo_count;

    sr_cmd_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .s          (s),
        .r          (r),
        .clear      (clear),
        .preset     (preset),
        .busy       (busy),
        .err        (err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a;    // edge at which the command was accepted
        int         st;   // first cycle its pattern is on the outputs
        logic [2:0] op;
        logic [3:0] len;
    } cmd_t;

    cmd_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    // {s, r, clear, preset} for an opcode
    function automatic logic [3:0] exp_pat(input logic [2:0] op);
        case (op)
            3'd1: return 4'b1000;
            3'd2: return 4'b0100;
`ifdef SR_BOTH_BLOCK_EN
            3'd3: return 4'b0000;
`else
            3'd3: return 4'b1100;
`endif
            3'd4: return 4'b0010;
            3'd5: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_bad(input logic [2:0] op);
`ifdef SR_BOTH_BLOCK_EN
        return (op >= 3'd6) || (op == 3'd3);
`else
        return (op >= 3'd6);
`endif
    endfunction

    // Expected {s,r,clear,preset, err, busy, cmd_ready, fifo_count[2:0]}
    function automatic logic [9:0] model_at(input int c);
        logic [3:0] p;
        logic       e;
        logic       b;
        int         n;
        p = 4'b0000;
        e = 1'b0;
        b = 1'b0;
        n = 0;
        foreach (q[i]) begin
            if (q[i].a <= c) n++;
            if (q[i].st <= c) n--;
            if (c >= q[i].st && c <= q[i].st + int'(q[i].len)) begin
                p = exp_pat(q[i].op);
                e = (c == q[i].st) && exp_bad(q[i].op);
            end
            if (c >= q[i].st && c <= q[i].st + int'(q[i].len) + 1) b = 1'b1;
        end
        return {p, e, b, (n < DEPTH), 3'(n)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {s, r, clear, preset, err, busy, cmd_ready, fifo_count};
    endfunction

    // Drive one cycle of stimulus, record acceptance in the model, advance.
    task automatic tick(input logic v, input logic [2:0] op, input logic [3:0] len);
        logic [9:0] m;
        cmd_t       c;
        int         pe;
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
        m = model_at(cyc);
        if (v && m[3]) begin
            c.a   = cyc + 1;
            c.st  = cyc + 2;
            c.op  = op;
            c.len = len;
            if (q.size() > 0) begin
                pe = q[$].st + int'(q[$].len) + 2;
                if (pe > c.st) c.st = pe;
            end
            q.push_back(c);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 10'b0000_0_0_1_000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec(), 10'b0000_0_0_1_000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        cyc = 0;
        checks++;
        if (dut_vec() !== model_at(cyc)) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", dut_vec(), model_at(cyc));
        end
    endtask

    task automatic test_set_len2();
        int s_cycles;
        s_cycles = 0;
        tick(1'b1, 3'd1, 4'd2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL set_len2 cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            if (s) s_cycles++;
            tick(1'b0, 3'd0, 4'd0);
        end
        checks++;
        if (s_cycles !== 3) begin
            errors++;
            $display("FAIL set_len2_width got=%0d exp=3", s_cycles);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 3'd1, 4'd0);
        checks++;
        if (dut_vec() !== model_at(cyc)) begin
            errors++;
            $display("FAIL b2b_accept cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
        end
        tick(1'b1, 3'd2, 4'd1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            tick(1'b0, 3'd0, 4'd0);
        end
    endtask

    task automatic test_fill();
        int   pushed;
        int   max_cnt;
        logic saw_full;
        pushed   = 0;
        max_cnt  = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 125; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL fill cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!cmd_ready && fifo_count == 3'd4) saw_full = 1'b1;
            if (pushed < 6 && model_at(cyc) & 10'b0000_0_0_1_000) pushed++;
            tick(pushed < 6, 3'($urandom_range(1, 5)), 4'd15);
        end
        checks++;
        if (max_cnt > DEPTH || saw_full !== 1'b1 || pushed !== 6) begin
            errors++;
            $display("FAIL fill_limits got max=%0d full=%b pushed=%0d exp max<=4 full=1 pushed=6",
                     max_cnt, saw_full, pushed);
        end
    endtask

    task automatic test_both_and_reserved();
        int err_pulses;
        err_pulses = 0;
        tick(1'b1, 3'd3, 4'd1);
        tick(1'b1, 3'd7, 4'd0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL both_reserved cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            if (err) err_pulses++;
            tick(1'b0, 3'd0, 4'd0);
        end
        checks++;
`ifdef SR_BOTH_BLOCK_EN
        if (err_pulses !== 2) begin
            errors++;
            $display("FAIL err_pulse_count got=%0d exp=2", err_pulses);
        end
`else
        if (err_pulses !== 1) begin
            errors++;
            $display("FAIL err_pulse_count got=%0d exp=1", err_pulses);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            tick(1'b0, 3'd0, 4'd0);
        end
    endtask

    task automatic test_reset_mid_drive();
        logic preset_seen;
        preset_seen = 1'b0;
        tick(1'b1, 3'd4, 4'd3);
        tick(1'b1, 3'd5, 4'd0);
        checks++;
        if (dut_vec() !== model_at(cyc) || clear !== 1'b1) begin
            errors++;
            $display("FAIL clear_start cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 10'b0000_0_0_1_000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), 10'b0000_0_0_1_000);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut_vec() !== model_at(cyc)) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_at(cyc));
            end
            if (preset) preset_seen = 1'b1;
            tick(1'b0, 3'd0, 4'd0);
        end
        checks++;
        if (preset_seen !== 1'b0) begin
            errors++;
            $display("FAIL preset_discarded got=%b exp=0", preset_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_set_len2();
        test_back_to_back();
        test_fill();
        test_both_and_reserved();
        test_random();
        test_reset_mid_drive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
